// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: buffers encoded letters in an external dual-port RAM and
// launches them one at a time to an IR transmitter, tracking its busy handshake.
module ir_tx_scheduler #(
  parameter int DEPTH = 1000,
  parameter int READ_LATENCY = 2,
  parameter int BUSY_TIMEOUT = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          enable_in,
  input  logic          letter_valid_in,
  input  logic [4:0]    letter_in,
  output logic          ram_wr_en_out,
  output logic [AW-1:0] ram_wr_addr_out,
  output logic [4:0]    ram_wr_data_out,
  output logic [AW-1:0] ram_rd_addr_out,
  input  logic [4:0]    ram_rd_data_in,
  input  logic          tx_busy_in,
  output logic          tx_valid_out,
  output logic [4:0]    tx_data_out,
  output logic [CW-1:0] count_out,
  output logic          full_out,
  output logic          empty_out,
  output logic          overflow_out,
  output logic          timeout_out,
  output logic          tx_done_out
);
  localparam int DW = $clog2(READ_LATENCY + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, READ_WAIT, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO} state_t;
  state_t        r_state;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_pop_addr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_delay;
  logic [TW-1:0] r_tcnt;
  logic [4:0]    r_tx_data;
  logic          r_tx_valid, r_tx_done, r_overflow, r_timeout;
  logic          w_wr, w_pop;
  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_out        = !rst_in && r_count == CW'(DEPTH);
  assign empty_out       = rst_in || r_count == '0;
  assign w_wr            = letter_valid_in && !full_out && !rst_in;
  assign w_pop           = r_state == IDLE && enable_in && !empty_out && !tx_busy_in;
  assign ram_wr_en_out   = w_wr;
  assign ram_wr_addr_out = r_wr_ptr;
  assign ram_wr_data_out = letter_in;
  // In IDLE the head address is already on the read port, so the RAM pipeline
  // has filled by the time the delay counter expires.
  assign ram_rd_addr_out = r_state == READ_WAIT ? r_pop_addr : r_rd_ptr;
  assign count_out       = r_count;
  assign tx_valid_out    = r_tx_valid;
  assign tx_data_out     = r_tx_data;
  assign tx_done_out     = r_tx_done;
  assign overflow_out    = r_overflow;
  assign timeout_out     = r_timeout;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pop_addr <= '0;
      r_count    <= '0;
      r_delay    <= '0;
      r_tcnt     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_tx_done  <= 1'b0;
      r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_wr) r_wr_ptr <= inc_ptr(r_wr_ptr);
      if (letter_valid_in && full_out) r_overflow <= 1'b1;
      case (r_state)
        IDLE: if (w_pop) begin
          r_rd_ptr   <= inc_ptr(r_rd_ptr);
          r_pop_addr <= r_rd_ptr;
          r_delay    <= DW'(READ_LATENCY - 1);
          r_state    <= READ_WAIT;
        end
        READ_WAIT: if (r_delay == '0) begin
          r_tx_data  <= ram_rd_data_in;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end else r_delay <= r_delay - 1'b1;
        SEND: begin
          r_tcnt  <= '0;
          r_state <= WAIT_BUSY_HI;
        end
        WAIT_BUSY_HI: if (tx_busy_in) r_state <= WAIT_BUSY_LO;
        else if (r_tcnt == TW'(BUSY_TIMEOUT - 1)) begin
          r_timeout <= 1'b1;
          r_state   <= IDLE;
        end else r_tcnt <= r_tcnt + 1'b1;
        WAIT_BUSY_LO: if (!tx_busy_in) begin
          r_tx_done <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ir_tx_scheduler.md
IR_TX_SCHEDULER -- requirements
Module: ir_tx_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 1000: letter buffer entries, external RAM depth.
REQ-002 SHALL have parameter READ_LATENCY, default 2: cycles from ram_rd_addr_out to valid ram_rd_data_in.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 16: max cycles to wait for tx_busy_in to rise after launch.
REQ-004 SHALL have port clk_in  input  1  sole clock; every input is sampled on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port enable_in  input  1  when high, new transmissions may launch.
REQ-007 SHALL have port letter_valid_in  input  1  one-cycle write request from encoder.
REQ-008 SHALL have port letter_in  input  5  letter code 0-25.
REQ-009 SHALL have port ram_wr_en_out  output  1  RAM port A write enable.
REQ-010 SHALL have port ram_wr_addr_out  output  $clog2(DEPTH)  RAM write address.
REQ-011 SHALL have port ram_wr_data_out  output  5  RAM write data.
REQ-012 SHALL have port ram_rd_addr_out  output  $clog2(DEPTH)  RAM port B read address.
REQ-013 SHALL have port ram_rd_data_in  input  5  RAM port B read data.
REQ-014 SHALL have port tx_busy_in  input  1  busy flag from IR transmitter.
REQ-015 SHALL have port tx_valid_out  output  1  one-cycle launch pulse to transmitter.
REQ-016 SHALL have port tx_data_out  output  5  letter to transmit; held stable until the next launch.
REQ-017 SHALL have ports count_out (output, $clog2(DEPTH+1): occupancy), full_out and empty_out (output, 1 each: occupancy flags).
REQ-018 SHALL have ports overflow_out and timeout_out (output, 1 each: sticky error flags), and tx_done_out (output, 1: one-cycle pulse per completed letter).

Function
REQ-019 SHALL drive ram_wr_en_out = letter_valid_in && !full_out, ram_wr_addr_out = wr_ptr and ram_wr_data_out = letter_in combinationally.
REQ-020 SHALL advance wr_ptr by 1 on each accepted write, wrapping from DEPTH-1 to 0.
REQ-021 SHALL drop a write while full_out=1 and set overflow_out, which holds until reset; pointers and count are unchanged.
REQ-022 SHALL keep count_out = number of stored letters, with full_out = (count_out==DEPTH) and empty_out = (count_out==0).
REQ-023 SHALL leave count_out unchanged when an accepted write and a pop occur in the same cycle.
REQ-024 SHALL implement FSM states IDLE, READ_WAIT, SEND, WAIT_BUSY_HI and WAIT_BUSY_LO.
REQ-025 SHALL, in IDLE, pop when enable_in && !empty_out && !tx_busy_in, entering READ_WAIT on that edge.
  - pop: rd_ptr advances by 1 with wrap, count_out decrements, delay counter loads READ_LATENCY-1.
REQ-026 SHALL drive ram_rd_addr_out as the popped address throughout READ_WAIT, and as rd_ptr otherwise.
REQ-027 SHALL, in READ_WAIT, decrement the delay counter each cycle; at 0, register ram_rd_data_in into tx_data_out and go to SEND.
REQ-028 SHALL assert tx_valid_out for exactly the one cycle spent in SEND, then go to WAIT_BUSY_HI with the timeout counter cleared.
  - Launch occurs READ_LATENCY+1 cycles after the pop edge.
REQ-029 SHALL, in WAIT_BUSY_HI, go to WAIT_BUSY_LO when tx_busy_in=1.
  - Otherwise the timeout counter increments.
  - At BUSY_TIMEOUT the FSM returns to IDLE, sets timeout_out (sticky) and does not pulse tx_done_out.
REQ-030 SHALL, in WAIT_BUSY_LO, on tx_busy_in=0 pulse tx_done_out for one cycle and return to IDLE.
  - The next pop may occur no earlier than the following cycle.
REQ-031 SHALL NOT abort an in-flight letter when enable_in falls; enable_in gates only new pops.
REQ-032 SHALL never pop a letter written in the same cycle; the pop decision uses registered count_out.

Reset
REQ-033 SHALL, while rst_in=1 at a clock edge, clear all of the following on that edge:
  - wr_ptr, rd_ptr, count_out, tx_data_out, tx_valid_out, tx_done_out, overflow_out, timeout_out and all counters;
  - FSM returns to IDLE.
REQ-034 SHALL, during reset cycles, hold empty_out=1, full_out=0 and ram_wr_en_out=0, and ignore letter_valid_in.
REQ-035 SHALL abandon any in-flight letter when reset occurs mid-operation, with no tx_done_out pulse.

Verification
REQ-036 SHALL cover single letter (DEPTH=1000, READ_LATENCY=2):
  - stimulus: write letter 7; transmitter busy goes high 1 cycle after launch and stays high 50 cycles.
  - response: tx_valid_out pulses 3 cycles after the pop with tx_data_out=7; tx_done_out pulses once; count returns to 0.
REQ-037 SHALL cover FIFO order: write 3, 1, 25 back-to-back -> transmitted 3, 1, 25 in order; count_out sequence 3, 2, 1, 0.
REQ-038 SHALL cover full/overflow (DEPTH=4, enable_in=0):
  - stimulus: 5 writes.
  - response: full_out=1, count_out=4, overflow_out=1; 5th letter absent after draining.
REQ-039 SHALL cover wrap-around (DEPTH=4): 6 writes interleaved with 6 transmissions -> write/read addresses sequence 0,1,2,3,0,1; data matches.
REQ-040 SHALL cover timeout: tx_busy_in held 0 after launch -> timeout_out=1 exactly BUSY_TIMEOUT cycles after SEND; next letter still launches.
REQ-041 SHALL cover reset mid-flight: rst_in pulsed during WAIT_BUSY_LO with 2 letters queued -> count_out=0, no tx_done_out pulse, FSM in IDLE.
